// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard control unit.
package hazard_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int LOAD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_HOLD  = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle for the hazard control unit.
// All signals are levels sampled every cycle: there is no valid/ready
// handshake; the unit reacts combinationally to the ID/EX/MEM inputs in the
// same cycle and the pipeline obeys the enables it returns.
interface hazard_ctrl_unit_if import hazard_pkg::*; #(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_SRC = 2
) ();
  logic                      ex_memread_i;
  logic [REG_AW-1:0]         ex_rd_i;
  logic [NUM_SRC*REG_AW-1:0] id_rs_i;
  logic [NUM_SRC-1:0]        id_rs_used_i;
  logic                      branch_taken_i;
  logic                      mem_stall_i;
  logic                      pc_write_o;
  logic                      if_id_write_o;
  logic                      noop_o;
  logic                      if_flush_o;
  logic                      pipe_stall_o;
  logic                      busy_o;
  hz_state_e                 dbg_state_o;

  // Pipeline side: drives stage information, receives controls.
  modport master (
    output ex_memread_i, ex_rd_i, id_rs_i, id_rs_used_i, branch_taken_i, mem_stall_i,
    input  pc_write_o, if_id_write_o, noop_o, if_flush_o, pipe_stall_o, busy_o, dbg_state_o
  );

  // Hazard unit side.
  modport slave (
    input  ex_memread_i, ex_rd_i, id_rs_i, id_rs_used_i, branch_taken_i, mem_stall_i,
    output pc_write_o, if_id_write_o, noop_o, if_flush_o, pipe_stall_o, busy_o, dbg_state_o
  );
endinterface

// File: rtl/hazard_src_cmp.sv
// Load-use comparator: flags when any used ID source matches a nonzero
// destination of a load sitting in EX.
module hazard_src_cmp #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                      ex_memread_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  output logic                      lu_hit_o
);
  logic any_match;

  // OR-reduce per-source matches; x0 is never a real dependency.
  always_comb begin
    any_match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_rs_used_i[k] && (id_rs_i[k*REG_AW +: REG_AW] == ex_rd_i)) begin
        any_match = 1'b1;
      end
    end
    lu_hit_o = ex_memread_i && (ex_rd_i != '0) && any_match;
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage pipeline: load-use bubbles (LOAD_LAT deep),
// data-memory freeze with resume, and branch IF/ID flush arbitration.
// Optional HAZARD_PERF_EN adds saturating cycle counters for bubbles,
// freezes and flushes.
module hazard_ctrl_unit import hazard_pkg::*; #(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_ctrl_unit_if.slave  hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        lu_stall_cnt_o,
  output logic [31:0]        mem_stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  hz_state_e  state_q, state_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       lu_hit;

  hazard_src_cmp #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) u_src_cmp (
    .ex_memread_i (hz.ex_memread_i),
    .ex_rd_i      (hz.ex_rd_i),
    .id_rs_i      (hz.id_rs_i),
    .id_rs_used_i (hz.id_rs_used_i),
    .lu_hit_o     (lu_hit)
  );

  // State and hold counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and controls; a resume cycle out of MEM_WAIT behaves as the
  // state it resumes into, so no extra cycle is lost.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    hz.pc_write_o    = 1'b1;
    hz.if_id_write_o = 1'b1;
    hz.noop_o        = 1'b0;
    hz.if_flush_o    = 1'b0;
    hz.pipe_stall_o  = 1'b0;
    eff_state        = state_q;
    if (state_q == HZ_MEM_WAIT) begin
      eff_state = (cnt_q != '0) ? HZ_LU_HOLD : HZ_RUN;
    end
    if (hz.mem_stall_i) begin
      hz.pipe_stall_o  = 1'b1;
      hz.pc_write_o    = 1'b0;
      hz.if_id_write_o = 1'b0;
      state_d          = HZ_MEM_WAIT;
    end else if (eff_state == HZ_LU_HOLD) begin
      hz.pc_write_o    = 1'b0;
      hz.if_id_write_o = 1'b0;
      hz.noop_o        = 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d = HZ_RUN;
        cnt_d   = '0;
      end else begin
        state_d = HZ_LU_HOLD;
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end else begin
      state_d = HZ_RUN;
      if (lu_hit) begin
        hz.pc_write_o    = 1'b0;
        hz.if_id_write_o = 1'b0;
        hz.noop_o        = 1'b1;
        if (LOAD_LAT > 1) begin
          state_d = HZ_LU_HOLD;
          cnt_d   = CNT_W'(LOAD_LAT - 1);
        end
      end else if (hz.branch_taken_i) begin
        hz.if_flush_o = 1'b1;
      end
    end
  end

  assign hz.busy_o      = (state_q != HZ_RUN);
  assign hz.dbg_state_o = state_q;

`ifdef HAZARD_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lu_stall_cnt_o  <= '0;
      mem_stall_cnt_o <= '0;
      flush_cnt_o     <= '0;
    end else begin
      if (hz.noop_o && (lu_stall_cnt_o != '1))        lu_stall_cnt_o  <= lu_stall_cnt_o + 32'd1;
      if (hz.pipe_stall_o && (mem_stall_cnt_o != '1)) mem_stall_cnt_o <= mem_stall_cnt_o + 32'd1;
      if (hz.if_flush_o && (flush_cnt_o != '1))       flush_cnt_o     <= flush_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LOAD_LAT=1 and 3) share one
// stimulus stream; a bubble-debt reference model predicts each cycle's
// controls, and a negedge monitor pops and compares them.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int W  = 6;  // {pc_write, if_id_write, noop, if_flush, pipe_stall, busy}

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  hazard_ctrl_unit_if #(.REG_AW(AW), .NUM_SRC(NS)) hz1 ();
  hazard_ctrl_unit_if #(.REG_AW(AW), .NUM_SRC(NS)) hz3 ();

`ifdef HAZARD_PERF_EN
  logic [31:0] lu1, mem1, fl1, lu3, mem3, fl3;
`endif

  hazard_ctrl_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1)) dut1 (
    .clk_i (clk_i), .rst_i (rst_i), .hz (hz1)
`ifdef HAZARD_PERF_EN
    , .lu_stall_cnt_o (lu1), .mem_stall_cnt_o (mem1), .flush_cnt_o (fl1)
`endif
  );

  hazard_ctrl_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3)) dut3 (
    .clk_i (clk_i), .rst_i (rst_i), .hz (hz3)
`ifdef HAZARD_PERF_EN
    , .lu_stall_cnt_o (lu3), .mem_stall_cnt_o (mem3), .flush_cnt_o (fl3)
`endif
  );

  // Shared stimulus
  logic          s_mr, s_br, s_st;
  logic [AW-1:0] s_rd, s_rs0, s_rs1;
  logic [NS-1:0] s_used;
  always_comb begin
    hz1.ex_memread_i = s_mr;   hz3.ex_memread_i = s_mr;
    hz1.ex_rd_i = s_rd;        hz3.ex_rd_i = s_rd;
    hz1.id_rs_i = {s_rs1, s_rs0}; hz3.id_rs_i = {s_rs1, s_rs0};
    hz1.id_rs_used_i = s_used; hz3.id_rs_used_i = s_used;
    hz1.branch_taken_i = s_br; hz3.branch_taken_i = s_br;
    hz1.mem_stall_i = s_st;    hz3.mem_stall_i = s_st;
  end

  // Scoreboard
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: outstanding bubble debt per load-use plus whether the
  // previous cycle was frozen (that cycle still reports busy).
  int          m_lat[2] = '{1, 3};
  int          m_pend[2];
  bit          m_prev_st[2];
  logic [31:0] m_lu[2], m_mem[2], m_fl[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 0; m_prev_st[d] = 1'b0;
      m_lu[d] = 0; m_mem[d] = 0; m_fl[d] = 0;
    end
  endtask

  task automatic apply(input bit rst, input bit mr, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                       input logic [NS-1:0] used, input bit br, input bit st);
    logic [W-1:0] e;
    bit hit, busy;
    @(posedge clk_i);
    #1;
    rst_i = rst; s_mr = mr; s_rd = rd; s_rs0 = rs0; s_rs1 = rs1;
    s_used = used; s_br = br; s_st = st;
    hit = mr && (rd != 0) && ((used[0] && rs0 == rd) || (used[1] && rs1 == rd));
    if (!rst) model_reset();
    for (int d = 0; d < 2; d++) begin
      busy = m_prev_st[d] || (m_pend[d] > 0);
      if (st)                   e = {5'b00001, busy};
      else if (m_pend[d] > 0) begin e = {5'b00100, busy}; m_pend[d]--; end
      else if (hit)           begin e = {5'b00100, busy}; m_pend[d] = m_lat[d] - 1; end
      else if (br)              e = {5'b11010, busy};
      else                      e = {5'b11000, busy};
      if (e[3] && m_lu[d]  != 32'hFFFF_FFFF) m_lu[d]++;
      if (e[1] && m_mem[d] != 32'hFFFF_FFFF) m_mem[d]++;
      if (e[2] && m_fl[d]  != 32'hFFFF_FFFF) m_fl[d]++;
      m_prev_st[d] = st;
      if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
    if (!rst) model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(rst_i, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // Monitor: compare the outputs presented in the cycle just driven.
  always @(negedge clk_i) begin
    logic [W-1:0] a, e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = {hz1.pc_write_o, hz1.if_id_write_o, hz1.noop_o, hz1.if_flush_o, hz1.pipe_stall_o, hz1.busy_o};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL lat1_ctrl t=%0t actual=%b required=%b", $time, a, e);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = {hz3.pc_write_o, hz3.if_id_write_o, hz3.noop_o, hz3.if_flush_o, hz3.pipe_stall_o, hz3.busy_o};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL lat3_ctrl t=%0t actual=%b required=%b", $time, a, e);
      end
    end
  end

`ifdef HAZARD_PERF_EN
  task automatic check_perf(input string tag);
    logic [95:0] a1, a3, e1, e3;
    a1 = {lu1, mem1, fl1}; e1 = {m_lu[0], m_mem[0], m_fl[0]};
    a3 = {lu3, mem3, fl3}; e3 = {m_lu[1], m_mem[1], m_fl[1]};
    n_vec += 2;
    if (a1 !== e1) begin n_err++; $display("FAIL perf1_%s actual=%h required=%h", tag, a1, e1); end
    if (a3 !== e3) begin n_err++; $display("FAIL perf3_%s actual=%h required=%h", tag, a3, e3); end
  endtask
`endif

  initial begin
    s_mr = 0; s_rd = 0; s_rs0 = 0; s_rs1 = 0; s_used = 0; s_br = 0; s_st = 0;
    model_reset();
    apply(0, 0, 0, 0, 0, 2'b00, 0, 0);
    apply(0, 0, 0, 0, 0, 2'b00, 0, 0);
    apply(1, 0, 0, 0, 0, 2'b00, 0, 0);   // idle after reset
    idle(1);
    // single load-use hit on src0
    apply(1, 1, 5, 5, 0, 2'b01, 0, 0);
    idle(4);
    // x0 destination and unused source never stall
    apply(1, 1, 0, 0, 0, 2'b01, 0, 0);
    apply(1, 1, 5, 5, 5, 2'b00, 0, 0);
    // hit on src1
    apply(1, 1, 9, 3, 9, 2'b10, 0, 0);
    idle(4);
    // freeze in the middle of the hold
    apply(1, 1, 7, 7, 0, 2'b01, 0, 0);
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 0, 0, 2'b00, 0, 1);
    idle(4);
    // branch together with a hit, then branch alone
    apply(1, 1, 4, 0, 4, 2'b10, 1, 0);
    apply(1, 0, 0, 0, 0, 2'b00, 1, 0);
    apply(1, 0, 0, 0, 0, 2'b00, 1, 0);
    apply(1, 0, 0, 0, 0, 2'b00, 1, 0);
    idle(2);
    // reset asserted while frozen
    apply(1, 1, 6, 6, 0, 2'b01, 0, 0);
    apply(1, 0, 0, 0, 0, 2'b00, 0, 1);
    apply(1, 0, 0, 0, 0, 2'b00, 0, 1);
`ifdef HAZARD_PERF_EN
    @(negedge clk_i);
    #1;
    check_perf("pre_reset");
`endif
    apply(0, 0, 0, 0, 0, 2'b00, 0, 0);
`ifdef HAZARD_PERF_EN
    @(negedge clk_i);
    #1;
    check_perf("in_reset");
`endif
    apply(1, 0, 0, 0, 0, 2'b00, 0, 0);
    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 40),
            AW'($urandom_range(0, 6)),
            AW'($urandom_range(0, 6)),
            AW'($urandom_range(0, 6)),
            NS'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 15));
    end
    apply(1, 0, 0, 0, 0, 2'b00, 0, 0);
    idle(4);
    @(negedge clk_i);
    #1;
`ifdef HAZARD_PERF_EN
    check_perf("end");
`endif
    n_vec++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Next-generation hazard control for the 5-stage RISC-V pipeline. It extends plain load-use detection with several features:
- parametrised register-address width and source count;
- multi-cycle load-use bubbles for deeper data-memory stages;
- data-memory stall freeze with resume;
- branch-taken IF/ID flush arbitration.

It sits beside the ID stage and drives the PC, IF/ID, ID/EX and global pipeline-freeze controls.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of ID-stage source operands checked (1..3)
LOAD_LAT, 1, load-use bubble count (1..4); 1 = classic single bubble
CNT_W, $clog2(LOAD_LAT+1), hold-counter width (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
ex_memread_i  in  1  instruction in EX is a load
ex_rd_i  in  REG_AW  EX-stage destination register
id_rs_i  in  NUM_SRC*REG_AW  ID-stage source registers; src k at bits [k*REG_AW +: REG_AW]
id_rs_used_i  in  NUM_SRC  per-source valid; an unused source never causes a hazard
branch_taken_i  in  1  branch resolved taken in ID this cycle
mem_stall_i  in  1  data memory busy; level, held until the access completes
pc_write_o  out  1  PC update enable
if_id_write_o  out  1  IF/ID register write enable
noop_o  out  1  insert bubble into ID/EX (zero control signals)
if_flush_o  out  1  clear IF/ID to NOP
pipe_stall_o  out  1  freeze every pipeline register, including EX/MEM and MEM/WB
busy_o  out  1  FSM not in RUN

Behaviour:
- FSM states: RUN, LU_HOLD, MEM_WAIT. Hold counter: cnt, width CNT_W.
- Reset (rst_i=0, asynchronous): state=RUN, cnt=0.
  - With idle inputs after reset: pc_write_o=1, if_id_write_o=1, noop_o=0, if_flush_o=0, pipe_stall_o=0, busy_o=0.
- Outputs are combinational from state, cnt and inputs. There is no extra latency, so a hazard is acted on in the same cycle it appears.
- lu_hit = ex_memread_i & (ex_rd_i!=0) & OR over k of (id_rs_used_i[k] & id_rs_k==ex_rd_i).
- Priority: mem_stall_i > load-use (lu_hit or LU_HOLD) > branch_taken_i.
- Output set per condition:
  - mem_stall_i=1 (any state): pipe_stall_o=1, pc_write_o=0, if_id_write_o=0, noop_o=0, if_flush_o=0.
  - load-use active: pc_write_o=0, if_id_write_o=0, noop_o=1, if_flush_o=0.
  - branch_taken_i only: if_flush_o=1, pc_write_o=1, if_id_write_o=1, noop_o=0.
  - none of the above: pc_write_o=1, if_id_write_o=1, noop_o=0, if_flush_o=0, pipe_stall_o=0.
- Transitions:
  - RUN, mem_stall_i -> MEM_WAIT; cnt unchanged.
  - RUN, lu_hit, LOAD_LAT>1 -> LU_HOLD; cnt=LOAD_LAT-1.
  - RUN, lu_hit, LOAD_LAT=1 -> stay RUN. This gives a single-cycle bubble.
  - LU_HOLD, no mem stall -> bubble asserted, lu_hit ignored, cnt decrements. When cnt==1, go to RUN (cnt=0).
  - LU_HOLD, mem_stall_i -> MEM_WAIT; cnt frozen.
  - MEM_WAIT, mem_stall_i=0 -> LU_HOLD if cnt!=0, else RUN. Outputs in that resume cycle follow the destination state's rules.
- Total bubbles per load-use = LOAD_LAT, excluding freeze cycles.
- A branch taken during load-use or freeze is suppressed. ID holds the branch, so it re-resolves later.
- busy_o=1 in LU_HOLD and MEM_WAIT.
- rst_i asserted mid-LU_HOLD or mid-MEM_WAIT: immediate return to RUN with cnt=0.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds output ports lu_stall_cnt_o, mem_stall_cnt_o and flush_cnt_o, each 32 bits.
  - They count cycles with noop_o=1, pipe_stall_o=1 and if_flush_o=1 respectively.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - state enum HZ_RUN/HZ_LU_HOLD/HZ_MEM_WAIT (2-bit);
  - REG_AW_DEF=5;
  - LOAD_LAT_MAX=4.
- One natural sub-module: hazard_src_cmp. It holds the parametrised NUM_SRC comparator producing lu_hit; the FSM stays in the top level.

Test Plan:
1. LOAD_LAT=1: ex_memread_i=1, ex_rd_i=5, id_rs_i src0=5, used=2'b01 -> pc_write_o=0, if_id_write_o=0, noop_o=1 for exactly 1 cycle; busy_o stays 0.
2. ex_rd_i=0 with id_rs src0=0 and load -> no stall. Source match with id_rs_used_i=0 -> no stall.
3. LOAD_LAT=3: load-use hit at cycle 0 -> noop_o=1 for cycles 0, 1, 2; busy_o=1 for cycles 1-2; normal outputs at cycle 3.
4. LOAD_LAT=3: mem_stall_i=1 for cycles 1-4 during the hold -> pipe_stall_o=1, noop_o=0 in cycles 1-4; noop_o=1 in cycles 5-6; RUN at cycle 7.
5. branch_taken_i=1 together with a load-use hit -> if_flush_o=0, noop_o=1. Next cycle with only branch_taken_i=1 -> if_flush_o=1, pc_write_o=1.
6. rst_i=0 asserted mid-MEM_WAIT with mem_stall_i=0 -> same cycle busy_o=0, pc_write_o=1. With HAZARD_PERF_EN defined, all counters read 0.
